// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath width, the NOP encoding and the
// fetched-instruction record passed from IF to ID.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// IF -> fetch queue -> ID handshake bundle. The master drives fetched
// instructions in and consumes the head; the slave is the queue itself.
interface fetch_queue_if #(
  parameter int XLEN = cpu_pkg::XLEN
);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc4;
  logic [XLEN-1:0] in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc4;
  logic [XLEN-1:0] out_inst;

  modport master (
    output in_valid, in_pc4, in_inst, out_ready,
    input  in_ready, out_valid, out_pc4, out_inst
  );

  modport slave (
    input  in_valid, in_pc4, in_inst, out_ready,
    output in_ready, out_valid, out_pc4, out_inst
  );

endinterface

// File: rtl/fetch_queue.sv
// Instruction buffer between IF and ID: circular FIFO that shows a NOP when empty.
// Optional FETCHQ_BYPASS_EN: an empty queue forwards the IF entry combinationally.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = cpu_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst_ID,
  input  logic                     flush,
  fetch_queue_if.slave             fq,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [AW:0]     cnt;
  logic [XLEN-1:0] pc4_mem  [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
  assign bypass = empty && fq.in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry taken by ID in the same cycle never touches storage.
  assign push = fq.in_valid && !full && !flush && !(bypass && fq.out_ready);
  assign pop  = !empty && fq.out_ready && !flush;

  assign fq.in_ready  = !full;
  assign fq.out_valid = !empty || bypass;
  assign count        = cnt;

  always_comb begin
    fq.out_pc4  = '0;
    fq.out_inst = XLEN'(NOP_INST);
    if (!empty) begin
      fq.out_pc4  = pc4_mem[rp];
      fq.out_inst = inst_mem[rp];
    end else if (bypass) begin
      fq.out_pc4  = fq.in_pc4;
      fq.out_inst = fq.in_inst;
    end
  end

  always_ff @(posedge clk or posedge rst_ID) begin
    if (rst_ID) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pc4_mem[wp]  <= fq.in_pc4;
      inst_mem[wp] <= fq.in_inst;
    end
  end

endmodule
